// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: imem requests, 2-entry insn queue, redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_re,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        run_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] q_pc   [2];
  logic [31:0] q_insn [2];
  logic        q_rd, q_wr;
  logic [1:0]  q_cnt;
  logic [31:0] tag [2];
  logic        t_rd, t_wr;
  logic [1:0]  outstanding;
  logic [1:0]  drop;

  logic        rsp, keep, pop, accept;
  logic [2:0]  credit_used;
  logic [1:0]  out_next;

  always_comb begin
    run_out     = (q_cnt != 2'd0) && run && !redirect_en;
    pop         = run_out && !stall;
    rsp         = imem_rvalid && (outstanding != 2'd0);
    keep        = rsp && (drop == 2'd0) && !redirect_en;
    // The slot freed by this cycle's pop is reusable now, which sustains one fetch per cycle
    credit_used = {1'b0, outstanding} + {1'b0, q_cnt} - {2'b00, pop};
    imem_re     = (state == FETCH) && !redirect_en && (credit_used < 3'd2);
    imem_addr   = fetch_pc;
    accept      = imem_re && imem_ready;
    out_next    = outstanding + 2'(accept) - 2'(rsp);
    insn        = (q_cnt != 2'd0) ? q_insn[q_rd] : NOP;
    pc          = (q_cnt != 2'd0) ? q_pc[q_rd] : fetch_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      q_pc[0]     <= '0;
      q_pc[1]     <= '0;
      q_insn[0]   <= '0;
      q_insn[1]   <= '0;
      q_rd        <= 1'b0;
      q_wr        <= 1'b0;
      q_cnt       <= 2'd0;
      tag[0]      <= '0;
      tag[1]      <= '0;
      t_rd        <= 1'b0;
      t_wr        <= 1'b0;
      outstanding <= 2'd0;
      drop        <= 2'd0;
    end else begin
      case (state)
        IDLE:    if (run)  state <= FETCH;
        FETCH:   if (!run) state <= IDLE;
        default: state <= IDLE;
      endcase

      outstanding <= out_next;

      if (accept) begin
        tag[t_wr] <= fetch_pc;
        t_wr      <= ~t_wr;
      end
      if (rsp) t_rd <= ~t_rd;

      if (redirect_en) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old path
        drop     <= out_next;
        q_cnt    <= 2'd0;
        q_rd     <= 1'b0;
        q_wr     <= 1'b0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && (drop != 2'd0)) drop <= drop - 2'd1;
        if (keep) begin
          q_pc[q_wr]   <= tag[t_rd];
          q_insn[q_wr] <= imem_rdata;
          q_wr         <= ~q_wr;
        end
        if (pop) q_rd <= ~q_rd;
        q_cnt <= q_cnt + 2'(keep) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with an in-order addr-as-data memory
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_re;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] insn, pc;
  logic        run_out;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_re(imem_re), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .insn(insn), .pc(pc), .run_out(run_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] sb[$];
  int          dl_cyc[$];
  logic [31:0] dl_pc[$];
  logic [31:0] exp_fetch;
  logic [31:0] last_pc;
  int          cyc, n_dl, mem_lat;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: memory answers, outputs sampled 1ns after the negedge, scoreboard updated.
  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr;
      pend.delete(0);
    end
    #1;
    if (run_out && !stall) begin
      if (sb.size() == 0) begin
        chk("dl_spurious", 32'(run_out), 32'd0);
      end else begin
        chk("dl_pc", pc, sb[0]);
        chk("dl_insn", insn, sb[0]);
        last_pc = pc;
        dl_pc.push_back(pc);
        dl_cyc.push_back(cyc);
        sb.delete(0);
      end
      n_dl++;
    end
    if (redirect_en) begin
      chk("redir_run_out", 32'(run_out), 32'd0);
      chk("redir_re", 32'(imem_re), 32'd0);
      sb.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
    if (imem_re && imem_ready) begin
      chk("req_addr", imem_addr, exp_fetch);
      pend.push_back('{exp_fetch, cyc + mem_lat});
      sb.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_dl(input int max);
    int start;
    int k;
    start = n_dl;
    k = 0;
    while (n_dl == start && k < max) begin
      tick();
      k++;
    end
    if (n_dl == start) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_re"}, 32'(imem_re), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_insn"}, insn, 32'h13);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_run_out"}, 32'(run_out), 32'd0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    exp_fetch = 32'h0; last_pc = 32'h0; cyc = 0; n_dl = 0; mem_lat = 1;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Start-up latency and back-to-back delivery
    run = 1'b1;
    repeat (5) tick();
    if (dl_cyc.size() >= 2) begin
      chk("first_dl_cyc", 32'(dl_cyc[0]), 32'd3);
      chk("second_dl_cyc", 32'(dl_cyc[1]), 32'd4);
      chk("first_dl_pc", dl_pc[0], 32'h0);
      chk("second_dl_pc", dl_pc[1], 32'h4);
    end else begin
      chk("startup_dl_count", 32'(dl_cyc.size()), 32'd2);
    end

    // Stall three cycles with pc 8 at the head
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_run_out", 32'(run_out), 32'd1);
      chk("stall_pc", pc, 32'h8);
      chk("stall_insn", insn, 32'h8);
      tick();
      chk("stall_credit", 32'(sb.size() <= 2), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("after_stall_8", last_pc, 32'h8);
    tick();
    chk("after_stall_12", last_pc, 32'hc);

    // Redirect with two-cycle memory so responses are in flight
    mem_lat = 2;
    repeat (6) tick();
    redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    wait_dl(20);
    chk("redir_first_pc", last_pc, 32'h100);

    // Unaligned redirect target
    mem_lat = 1;
    repeat (3) tick();
    redirect_en = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_en = 1'b0;
    wait_dl(20);
    chk("redir_unaligned_pc", last_pc, 32'h100);

    // Memory back-pressure
    repeat (3) tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_re", 32'(imem_re), 32'd1);
      chk("hold_addr", imem_addr, exp_fetch);
      tick();
    end
    imem_ready = 1'b1;
    wait_dl(20);
    repeat (4) tick();

    // Redirect while a response arrives and the head is valid
    chk("pre_redir_resp_pending", 32'(pend.size() > 0), 32'd1);
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    #1 chk("post_redir_empty", 32'(run_out), 32'd0);
    wait_dl(20);
    chk("redir_resp_pc", last_pc, 32'h200);

    // Reset mid-stream with a stalled, full queue
    stall = 1'b1;
    repeat (4) tick();
    chk("full_before_reset", 32'(sb.size()), 32'd2);
    reset = 1'b0;
    imem_rvalid = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    #1 chk_reset_outputs("mid_rst_next");
    pend.delete();
    sb.delete();
    exp_fetch = 32'h0;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_dl(20);
    chk("restart_pc", last_pc, 32'h0);
    wait_dl(5);
    chk("restart_pc_next", last_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
